ccff_loader: RTL and testbench

Configuration-chain loader for the fabric's `ccff_head`/`ccff_tail` shift chain (tiles daisy-chained `ccff_head` → `ccff_tail`, clocked by `prog_clk`).
- Accepts the bitstream as parallel words over a valid/ready handshake and serialises it one bit per shift cycle into the chain head.
- Drives a shift enable used to gate the chain clock, counts exactly `CHAIN_LEN` bits, and signals completion.
- Sits between the SoC-side programming interface and the first tile's `ccff_head`.

---
 rtl/ccff_loader.sv | 142 ++++++++++++++
 tb/tb_ccff_loader.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_loader.sv
// ccff_loader: serialises cfg words LSB-first into the ccff chain; `CCFF_READBACK_EN adds a CRC readback verify pass.
// Latency: word accepted at edge t -> bit0 on ccff_head at t+1; cfg_ready holds off until the word buffer drains.
module ccff_loader #(
  parameter int CHAIN_LEN = 1000,
  parameter int WORD_W    = 32
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              verify_err
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int REM_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {IDLE, LOAD, VERIFY, FINISH} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WORD_W-1:0] word_buf;
  logic [REM_W-1:0]  buf_rem;
  logic              streaming;
  logic              all_bits;
  logic              accept;
  logic              emit;
  logic              shift_bit;
  logic              start_load;
  logic              pass_end;

  assign streaming  = (state == LOAD) || (state == VERIFY);
  assign all_bits   = (bit_cnt == CNT_W'(CHAIN_LEN));
  assign start_load = (state == IDLE) && start;
  assign pass_end   = streaming && all_bits;
  assign accept     = cfg_valid && cfg_ready;
  // buf_rem counts bits still waiting behind ccff_head; a new word is taken the cycle it reaches 0
  assign emit       = streaming && !all_bits && (accept || (buf_rem != '0));
  assign shift_bit  = accept ? cfg_data[0] : word_buf[0];

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
`ifdef CCFF_READBACK_EN
      LOAD:    if (all_bits) state_nxt = VERIFY;
`else
      LOAD:    if (all_bits) state_nxt = FINISH;
`endif
      VERIFY:  if (all_bits) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    if (state != IDLE) busy = 1'b1;
    if (state == FINISH) done = 1'b1;
    if (streaming && !all_bits && (buf_rem == '0)) cfg_ready = 1'b1;
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      bit_cnt       <= '0;
      word_buf      <= '0;
      buf_rem       <= '0;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
    end else begin
      ccff_shift_en <= emit;
      // leftover upper bits of the final word are dropped here
      if (start_load || pass_end) begin
        bit_cnt  <= '0;
        word_buf <= '0;
        buf_rem  <= '0;
      end else if (emit) begin
        bit_cnt   <= bit_cnt + 1'b1;
        ccff_head <= shift_bit;
        if (accept) begin
          word_buf <= cfg_data >> 1;
          buf_rem  <= REM_W'(WORD_W - 1);
        end else begin
          word_buf <= word_buf >> 1;
          buf_rem  <= buf_rem - 1'b1;
        end
      end
    end
  end

`ifdef CCFF_READBACK_EN
  logic [15:0] crc_load;
  logic [15:0] crc_tail;
  logic [15:0] crc_tail_nxt;

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
    return {crc[14:0], 1'b0} ^ ((crc[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  assign crc_tail_nxt = ccff_shift_en ? crc16_step(crc_tail, ccff_tail) : crc_tail;

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      crc_load   <= 16'hFFFF;
      crc_tail   <= 16'hFFFF;
      verify_err <= 1'b0;
    end else if (start_load) begin
      crc_load   <= 16'hFFFF;
      crc_tail   <= 16'hFFFF;
      verify_err <= 1'b0;
    end else begin
      if ((state == LOAD) && ccff_shift_en) crc_load <= crc16_step(crc_load, ccff_head);
      // the last tail bit is folded in on the same edge as the compare
      if (state == VERIFY) begin
        crc_tail <= crc_tail_nxt;
        if (all_bits && (crc_tail_nxt != crc_load)) verify_err <= 1'b1;
      end
    end
  end
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign verify_err  = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_loader.sv
// Bench for ccff_loader: random word streams vs a bit-list model of the chain load; readback cases under CCFF_READBACK_EN.
module tb_ccff_loader;

  localparam int CHAIN_LEN = 40;
  localparam int WORD_W    = 32;
  localparam int WPP       = (CHAIN_LEN + WORD_W - 1) / WORD_W;
`ifdef CCFF_READBACK_EN
  localparam int NPASS = 2;
`else
  localparam int NPASS = 1;
`endif
  localparam logic [CHAIN_LEN-1:0] STUCK_MASK = CHAIN_LEN'(1) << 5;

  logic              prog_clk = 1'b0;
  logic              prog_reset;
  logic              start;
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;
  logic              ccff_head;
  logic              ccff_shift_en;
  logic              ccff_tail;
  logic              busy;
  logic              done;
  logic              verify_err;

  int checks = 0;
  int errors = 0;

  always #5 prog_clk = ~prog_clk;

  ccff_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W)) dut (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .ccff_head(ccff_head), .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail),
    .busy(busy), .done(done), .verify_err(verify_err)
  );

  // fabric chain: a plain shift register, optionally with one cell stuck at 1
  logic [CHAIN_LEN-1:0] chain = '0;
  bit stuck_en = 1'b0;
  always @(posedge prog_clk)
    if (ccff_shift_en) chain <= {chain[CHAIN_LEN-2:0], ccff_head} | (stuck_en ? STUCK_MASK : '0);
  assign ccff_tail = chain[CHAIN_LEN-1];

  logic [WORD_W-1:0] words[$];
  logic [WORD_W-1:0] drv_q[$];
  logic              exp_bits[$];
  int                sh_cyc[$];
  logic              sh_bit[$];
  logic              tail_bit[$];
  int                acc_cyc[$];
  int                done_cyc, done_cnt, held_bad, cyc;
  logic              first_busy, first_ready, first_verr, busy_after, verr_at_done, verr_after;

  // expected stream: first CHAIN_LEN bits of the word list, LSB first, once per pass
  task automatic prepare();
    logic [WORD_W-1:0] w;
    exp_bits.delete();
    drv_q.delete();
    for (int p = 0; p < NPASS; p++) begin
      for (int i = 0; i < CHAIN_LEN; i++) begin
        w = words[i / WORD_W];
        exp_bits.push_back(w[i % WORD_W]);
      end
      foreach (words[k]) drv_q.push_back(words[k]);
    end
  endtask

  function automatic int bit_errs();
    int e = 0;
    if (sh_bit.size() != exp_bits.size()) e++;
    for (int i = 0; i < sh_bit.size() && i < exp_bits.size(); i++)
      if (sh_bit[i] !== exp_bits[i]) e++;
    return e;
  endfunction

  function automatic int crc_bits(input bit from_tail);
    int c = 'hFFFF;
    int b;
    for (int i = 0; i < CHAIN_LEN; i++) begin
      if (from_tail) b = (i < tail_bit.size()) ? int'(tail_bit[i]) : 0;
      else           b = int'(exp_bits[i]);
      c = c << 1;
      if ((((c >> 16) & 1) ^ b) != 0) c = c ^ 'h1021;
      c = c & 'hFFFF;
    end
    return c;
  endfunction

  function automatic logic exp_verr();
    if (NPASS == 1) return 1'b0;
    return crc_bits(1'b0) != crc_bits(1'b1);
  endfunction

  function automatic int last_sh();
    return (sh_cyc.size() > 0) ? sh_cyc[sh_cyc.size()-1] : -100;
  endfunction

  // one start + stream of drv_q; records every cycle seen from the cycle after start
  task automatic stream(input int gap_len, input int poke_at, input int abort_at);
    int gap_left = 0;
    bit seen_first = 0;
    sh_cyc.delete(); sh_bit.delete(); tail_bit.delete(); acc_cyc.delete();
    done_cyc = -1; done_cnt = 0; held_bad = 0; cyc = 0;
    @(negedge prog_clk);
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    first_busy = busy; first_ready = cfg_ready; first_verr = verify_err;
    for (int n = 0; n < 600; n++) begin
      if (ccff_shift_en) begin
        sh_cyc.push_back(cyc);
        sh_bit.push_back(ccff_head);
        if (sh_bit.size() > CHAIN_LEN) tail_bit.push_back(ccff_tail);
      end else if (busy && sh_bit.size() > 0 && ccff_head !== sh_bit[sh_bit.size()-1]) begin
        held_bad++;
      end
      if (done_cyc >= 0) begin
        busy_after = busy; verr_after = verify_err;
        if (done) done_cnt++;
        break;
      end
      if (done) begin done_cyc = cyc; done_cnt++; verr_at_done = verify_err; end
      if (abort_at >= 0 && sh_bit.size() == abort_at) begin
        prog_reset = 1'b1; cfg_valid = 1'b0; start = 1'b0;
        @(posedge prog_clk);
        return;
      end
      start = (sh_bit.size() == poke_at);
      if (gap_left > 0 && cfg_ready) begin
        cfg_valid = 1'b0;
        gap_left--;
      end else begin
        cfg_valid = (drv_q.size() > 0);
      end
      cfg_data = cfg_valid ? drv_q[0] : WORD_W'($urandom);
      #1;
      if (cfg_valid && cfg_ready) begin
        acc_cyc.push_back(cyc);
        void'(drv_q.pop_front());
        if (!seen_first) begin seen_first = 1; gap_left = gap_len; end
      end
      @(negedge prog_clk);
      cyc++;
    end
    cfg_valid = 1'b0; start = 1'b0;
    checks++;
    if (done_cyc < 0) begin errors++; $display("FAIL stream_done: no done within budget, shifts %0d", sh_bit.size()); end
  endtask

  task automatic test_reset();
    prog_reset = 1'b1;
    repeat (3) @(negedge prog_clk);
    checks++; if (cfg_ready !== 1'b0)     begin errors++; $display("FAIL rst_ready: got %b want 0", cfg_ready); end
    checks++; if (ccff_head !== 1'b0)     begin errors++; $display("FAIL rst_head: got %b want 0", ccff_head); end
    checks++; if (ccff_shift_en !== 1'b0) begin errors++; $display("FAIL rst_shift: got %b want 0", ccff_shift_en); end
    checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0)          begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    checks++; if (verify_err !== 1'b0)    begin errors++; $display("FAIL rst_verr: got %b want 0", verify_err); end
    prog_reset = 1'b0;
  endtask

  task automatic test_continuous();
    words = '{32'h89ABCDEF, 32'h000000A5};
    prepare();
    stream(0, -1, -1);
    checks++; if (first_busy !== 1'b1)  begin errors++; $display("FAIL cont_busy1: got %b want 1", first_busy); end
    checks++; if (first_ready !== 1'b1) begin errors++; $display("FAIL cont_ready1: got %b want 1", first_ready); end
    checks++; if (sh_bit.size() != NPASS*CHAIN_LEN) begin errors++; $display("FAIL cont_count: got %0d want %0d", sh_bit.size(), NPASS*CHAIN_LEN); end
    checks++; if (bit_errs() != 0) begin errors++; $display("FAIL cont_bits: %0d bad bits want 0", bit_errs()); end
    checks++; if (sh_cyc.size() == 0 || acc_cyc.size() == 0 || sh_cyc[0] != acc_cyc[0] + 1)
      begin errors++; $display("FAIL cont_latency: first shift %0d want accept+1", sh_cyc.size() ? sh_cyc[0] : -1); end
    checks++; if (sh_cyc.size() < CHAIN_LEN || sh_cyc[CHAIN_LEN-1] - sh_cyc[0] != CHAIN_LEN-1)
      begin errors++; $display("FAIL cont_contig: pass spans %0d shifts want %0d consecutive", sh_cyc.size(), CHAIN_LEN); end
    checks++; if (acc_cyc.size() != NPASS*WPP) begin errors++; $display("FAIL cont_accepts: got %0d want %0d", acc_cyc.size(), NPASS*WPP); end
    checks++; if (acc_cyc.size() < 2 || acc_cyc[1] - acc_cyc[0] != WORD_W)
      begin errors++; $display("FAIL cont_spacing: accepts %0d apart want %0d", acc_cyc.size() >= 2 ? acc_cyc[1]-acc_cyc[0] : -1, WORD_W); end
    checks++; if (done_cyc != last_sh() + 1) begin errors++; $display("FAIL cont_done_cyc: got %0d want %0d", done_cyc, last_sh()+1); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL cont_done_width: got %0d want 1", done_cnt); end
    checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL cont_busy_after: got %b want 0", busy_after); end
    checks++; if (verr_at_done !== exp_verr()) begin errors++; $display("FAIL cont_verr: got %b want %b", verr_at_done, exp_verr()); end
  endtask

  task automatic test_gap();
    words = '{32'h89ABCDEF, 32'h000000A5};
    prepare();
    stream(5, -1, -1);
    checks++; if (sh_bit.size() != NPASS*CHAIN_LEN) begin errors++; $display("FAIL gap_count: got %0d want %0d", sh_bit.size(), NPASS*CHAIN_LEN); end
    checks++; if (bit_errs() != 0) begin errors++; $display("FAIL gap_bits: %0d bad bits want 0", bit_errs()); end
    checks++; if (sh_cyc.size() < CHAIN_LEN || sh_cyc[CHAIN_LEN-1] - sh_cyc[0] + 1 - CHAIN_LEN != 5)
      begin errors++; $display("FAIL gap_idle: idle cycles %0d want 5", sh_cyc.size() >= CHAIN_LEN ? sh_cyc[CHAIN_LEN-1]-sh_cyc[0]+1-CHAIN_LEN : -1); end
    checks++; if (held_bad != 0) begin errors++; $display("FAIL gap_hold: head moved in %0d idle cycles want 0", held_bad); end
  endtask

  task automatic test_random();
    int g;
    for (int it = 0; it < 4; it++) begin
      words = '{WORD_W'($urandom), WORD_W'($urandom)};
      g = $urandom_range(0, 3);
      prepare();
      stream(g, -1, -1);
      checks++; if (bit_errs() != 0) begin errors++; $display("FAIL rnd%0d_bits: %0d bad bits want 0 (gap %0d)", it, bit_errs(), g); end
      checks++; if (done_cyc != last_sh() + 1) begin errors++; $display("FAIL rnd%0d_done: got %0d want %0d", it, done_cyc, last_sh()+1); end
      checks++; if (verr_at_done !== exp_verr()) begin errors++; $display("FAIL rnd%0d_verr: got %b want %b", it, verr_at_done, exp_verr()); end
    end
  endtask

  task automatic test_start_ignored();
    logic [WORD_W-1:0] held;
    int bad_rdy = 0, bad_busy = 0;
    words = '{WORD_W'($urandom), WORD_W'($urandom)};
    prepare();
    stream(0, 10, -1);
    checks++; if (bit_errs() != 0) begin errors++; $display("FAIL poke_bits: %0d bad bits want 0", bit_errs()); end
    checks++; if (acc_cyc.size() != NPASS*WPP) begin errors++; $display("FAIL poke_accepts: got %0d want %0d", acc_cyc.size(), NPASS*WPP); end
    held = WORD_W'($urandom);
    for (int i = 0; i < 5; i++) begin
      @(negedge prog_clk);
      cfg_valid = 1'b1; cfg_data = held;
      #1;
      if (cfg_ready !== 1'b0) bad_rdy++;
      if (busy !== 1'b0) bad_busy++;
    end
    checks++; if (bad_rdy != 0)  begin errors++; $display("FAIL idle_ready: high in %0d cycles want 0", bad_rdy); end
    checks++; if (bad_busy != 0) begin errors++; $display("FAIL idle_busy: high in %0d cycles want 0", bad_busy); end
    words = '{held, WORD_W'($urandom)};
    prepare();
    stream(0, -1, -1);
    checks++; if (bit_errs() != 0) begin errors++; $display("FAIL idle_word_bits: %0d bad bits want 0", bit_errs()); end
    checks++; if (acc_cyc.size() == 0 || acc_cyc[0] != 0) begin errors++; $display("FAIL idle_word_accept: first accept cycle %0d want 0", acc_cyc.size() ? acc_cyc[0] : -1); end
  endtask

  task automatic test_reset_mid();
    words = '{WORD_W'($urandom) | 32'h0001_0000, WORD_W'($urandom)};
    prepare();
    stream(0, -1, 17);
    @(negedge prog_clk);
    checks++; if (cfg_ready !== 1'b0)     begin errors++; $display("FAIL mid_ready: got %b want 0", cfg_ready); end
    checks++; if (ccff_head !== 1'b0)     begin errors++; $display("FAIL mid_head: got %b want 0", ccff_head); end
    checks++; if (ccff_shift_en !== 1'b0) begin errors++; $display("FAIL mid_shift: got %b want 0", ccff_shift_en); end
    checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0)          begin errors++; $display("FAIL mid_done: got %b want 0", done); end
    prog_reset = 1'b0;
    words = '{WORD_W'($urandom), WORD_W'($urandom)};
    prepare();
    stream(0, -1, -1);
    checks++; if (sh_bit.size() != NPASS*CHAIN_LEN) begin errors++; $display("FAIL mid_reload_count: got %0d want %0d", sh_bit.size(), NPASS*CHAIN_LEN); end
    checks++; if (bit_errs() != 0) begin errors++; $display("FAIL mid_reload_bits: %0d bad bits want 0", bit_errs()); end
  endtask

`ifdef CCFF_READBACK_EN
  task automatic test_readback_err();
    stuck_en = 1'b1;
    words = '{32'h0000_0000, 32'h0000_0000};
    prepare();
    stream(0, -1, -1);
    checks++; if (verr_at_done !== exp_verr()) begin errors++; $display("FAIL rb_err_flag: got %b want %b", verr_at_done, exp_verr()); end
    checks++; if (verr_after !== exp_verr()) begin errors++; $display("FAIL rb_err_sticky: got %b want %b", verr_after, exp_verr()); end
    stuck_en = 1'b0;
  endtask

  task automatic test_readback_ok();
    words = '{WORD_W'($urandom), WORD_W'($urandom)};
    prepare();
    stream(1, -1, -1);
    checks++; if (first_verr !== 1'b0) begin errors++; $display("FAIL rb_clear_on_start: got %b want 0", first_verr); end
    checks++; if (tail_bit.size() != CHAIN_LEN) begin errors++; $display("FAIL rb_tail_count: got %0d want %0d", tail_bit.size(), CHAIN_LEN); end
    checks++; if (verr_at_done !== 1'b0) begin errors++; $display("FAIL rb_ok_flag: got %b want 0", verr_at_done); end
  endtask
`endif

  initial begin
    prog_reset = 1'b1;
    start      = 1'b0;
    cfg_valid  = 1'b0;
    cfg_data   = '0;
    test_reset();
    test_continuous();
    test_gap();
    test_random();
    test_start_ignored();
    test_reset_mid();
`ifdef CCFF_READBACK_EN
    test_readback_err();
    test_readback_ok();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
